// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor table controller.
// Counter encodings, FSM states and the saturating counter update.
package bp_pkg;

  localparam int IDX_W_DEF = 8;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    UPD_WR = 2'd2
  } bp_state_e;

  function automatic logic [1:0] bp_sat_upd(
    input logic [1:0] c,
    input logic       t
  );
    logic [1:0] r;
    r = c;
    case (c)
      SNT: r = t ? WNT : SNT;
      WNT: r = t ? WT  : SNT;
      WT:  r = t ? ST  : WNT;
      ST:  r = t ? ST  : WT;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding pending predictor updates.
// The sync clear drops all entries; clear wins over push/pop.
module bp_upd_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign dout    = mem[rp[AW-1:0]];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Arbitrates a single-port 2-bit predictor table between lookups and updates.
// Optional stall/update statistics are built when BP_CTRL_STATS_EN is defined.
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int         ENTRIES    = 256,
  parameter int         IDX_W      = IDX_W_DEF,
  parameter int         UPDQ_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = WNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  output logic             upd_ready,
  input  logic             flush_req,
  output logic             init_done,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic [15:0]      lookup_stall_count,
  output logic [15:0]      update_count
);

  localparam int QW = IDX_W + 1;

  bp_state_e        state;
  logic [IDX_W-1:0] sweep;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_tkn;
  logic             pv_q;

  logic             q_full;
  logic             q_empty;
  logic             q_push;
  logic [QW-1:0]    q_din;
  logic [QW-1:0]    q_dout;

  logic             do_lookup;
  logic             do_upd;
  logic             upd_wr;
  logic             unused_pc;

  assign unused_pc = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                       upd_pc[31:IDX_W+2], upd_pc[1:0]};

  assign q_push = upd_valid && !q_full;
  assign q_din  = {upd_pc[IDX_W+1:2], upd_taken};

  bp_upd_fifo #(
    .W     (QW),
    .DEPTH (UPDQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_req),
    .push  (q_push),
    .din   (q_din),
    .pop   (do_upd),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  // A full queue steals the port from fetch so updates cannot starve.
  always_comb begin
    do_lookup = 1'b0;
    do_upd    = 1'b0;
    if (state == RUN && !flush_req) begin
      if (q_full)            do_upd    = 1'b1;
      else if (lookup_valid) do_lookup = 1'b1;
      else if (!q_empty)     do_upd    = 1'b1;
    end
  end

  assign upd_wr       = (state == UPD_WR) && !flush_req;
  assign lookup_ready = do_lookup;
  assign upd_ready    = !q_full;
  assign init_done    = (state != INIT);
  assign pred_valid   = pv_q;
  assign pred_taken   = pv_q & tbl_rdata[1];

  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    if (!flush_req) begin
      unique case (state)
        INIT: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = sweep;
          tbl_wdata = INIT_VAL;
        end
        RUN: begin
          if (do_upd) begin
            tbl_en   = 1'b1;
            tbl_addr = q_dout[QW-1:1];
          end else if (do_lookup) begin
            tbl_en   = 1'b1;
            tbl_addr = lookup_pc[IDX_W+1:2];
          end
        end
        UPD_WR: begin
          tbl_en    = upd_wr;
          tbl_we    = upd_wr;
          tbl_addr  = upd_idx;
          tbl_wdata = bp_sat_upd(tbl_rdata, upd_tkn);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      sweep   <= '0;
      upd_idx <= '0;
      upd_tkn <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      pv_q <= do_lookup;
      if (flush_req) begin
        state <= INIT;
        sweep <= '0;
      end else begin
        unique case (state)
          INIT: begin
            sweep <= sweep + 1'b1;
            if (sweep == IDX_W'(ENTRIES - 1)) state <= RUN;
          end
          RUN: begin
            if (do_upd) begin
              upd_idx <= q_dout[QW-1:1];
              upd_tkn <= q_dout[0];
              state   <= UPD_WR;
            end
          end
          UPD_WR: state <= RUN;
          default: state <= INIT;
        endcase
      end
    end
  end

`ifdef BP_CTRL_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] updc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      updc_q  <= '0;
    end else begin
      if (lookup_valid && !lookup_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (upd_wr && updc_q != 16'hFFFF)
        updc_q <= updc_q + 16'd1;
    end
  end

  assign lookup_stall_count = stall_q;
  assign update_count       = updc_q;
`else
  assign lookup_stall_count = '0;
  assign update_count       = '0;
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl with a behavioural 1-cycle table RAM.
// Build with +define+BP_CTRL_STATS_EN to exercise the statistics counters.
module tb_bp_table_ctrl;

  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lookup_valid = 1'b0;
  logic [31:0]      lookup_pc = '0;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             upd_valid = 1'b0;
  logic [31:0]      upd_pc = '0;
  logic             upd_taken = 1'b0;
  logic             upd_ready;
  logic             flush_req = 1'b0;
  logic             init_done;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata = '0;
  logic [15:0]      lookup_stall_count;
  logic [15:0]      update_count;

  int n_cmp = 0;
  int n_bad = 0;

  bit         pq[$];
  logic [9:0] wq[$];
  logic [1:0] mem [256];

  always #5 clk = ~clk;

  bp_table_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lookup_valid       (lookup_valid),
    .lookup_pc          (lookup_pc),
    .lookup_ready       (lookup_ready),
    .pred_valid         (pred_valid),
    .pred_taken         (pred_taken),
    .upd_valid          (upd_valid),
    .upd_pc             (upd_pc),
    .upd_taken          (upd_taken),
    .upd_ready          (upd_ready),
    .flush_req          (flush_req),
    .init_done          (init_done),
    .tbl_en             (tbl_en),
    .tbl_we             (tbl_we),
    .tbl_addr           (tbl_addr),
    .tbl_wdata          (tbl_wdata),
    .tbl_rdata          (tbl_rdata),
    .lookup_stall_count (lookup_stall_count),
    .update_count       (update_count)
  );

  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: predictions and run-time table writes against queues
  always @(negedge clk) begin
    if (rst_n && pred_valid) begin
      if (pq.size() == 0) chk("pred_unexpected", 32'd1, 32'd0);
      else chk("pred_taken", {31'd0, pred_taken}, {31'd0, pq.pop_front()});
    end
    if (rst_n && tbl_en && tbl_we && init_done) begin
      if (wq.size() == 0)
        chk("write_unexpected", {22'd0, tbl_addr, tbl_wdata}, 32'hdead);
      else
        chk("upd_write", {22'd0, tbl_addr, tbl_wdata},
            {22'd0, wq.pop_front()});
    end
  end

  task automatic do_lookup(input logic [31:0] pc, input bit exp,
                           input logic [7:0] ea);
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    pq.push_back(exp);
    @(negedge clk);
    chk("lk_ready", {31'd0, lookup_ready}, 32'd1);
    chk("lk_addr", {24'd0, tbl_addr}, {24'd0, ea});
    @(posedge clk); #1;
    lookup_valid = 1'b0;
  endtask

  task automatic do_upd(input logic [31:0] pc, input bit t,
                        input logic [7:0] ea, input logic [1:0] ed);
    @(posedge clk); #1;
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = t;
    wq.push_back({ea, ed});
    @(negedge clk);
    chk("upd_ready", {31'd0, upd_ready}, 32'd1);
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
    chk("init_wait", {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cpc [4];
    bit          ctk [4];
    int          bad;
    cpc = '{32'h100, 32'h104, 32'h108, 32'h10C};
    ctk = '{1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_upd_ready", {31'd0, upd_ready}, 32'd1);
    chk("rst_lk_ready", {31'd0, lookup_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Init sweep: exactly 256 writes of 01
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!(tbl_en && tbl_we && tbl_addr == i[7:0] && tbl_wdata == 2'b01 &&
            !lookup_ready && !init_done)) bad++;
    end
    chk("init_sweep_bad", bad, 0);
    @(negedge clk);
    chk("init_done_256", {31'd0, init_done}, 32'd1);

    do_lookup(32'h10, 1'b0, 8'd4);
    do_upd(32'h10, 1'b1, 8'd4, 2'b10);
    do_upd(32'h10, 1'b1, 8'd4, 2'b11);
    do_upd(32'h10, 1'b1, 8'd4, 2'b11);
    repeat (4) @(posedge clk);
    do_lookup(32'h10, 1'b1, 8'd4);
    repeat (2) @(posedge clk);

    // Continuous lookups on idx 64 while 4 updates fill the queue
    pq.push_back(1'b0); pq.push_back(1'b0);
    pq.push_back(1'b0); pq.push_back(1'b0);
    pq.push_back(1'b1); pq.push_back(1'b1);
    wq.push_back({8'd64, 2'b10});
    wq.push_back({8'd65, 2'b10});
    wq.push_back({8'd66, 2'b00});
    wq.push_back({8'd67, 2'b00});
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      lookup_valid = 1'b1;
      lookup_pc    = 32'h100;
      upd_valid    = (c < 4);
      if (c < 4) begin
        upd_pc    = cpc[c];
        upd_taken = ctk[c];
      end
      @(negedge clk);
      if (c == 4) begin
        chk("full_upd_ready", {31'd0, upd_ready}, 32'd0);
        chk("full_lk_ready", {31'd0, lookup_ready}, 32'd0);
        chk("full_rd_addr", {24'd0, tbl_addr}, 32'd64);
        chk("full_rd_we", {31'd0, tbl_we}, 32'd0);
      end
      if (c == 5) begin
        chk("updwr_lk_ready", {31'd0, lookup_ready}, 32'd0);
        chk("updwr_we", {31'd0, tbl_we}, 32'd1);
      end
      if (c == 6) chk("after_wr_lk_ready", {31'd0, lookup_ready}, 32'd1);
    end
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    repeat (10) @(posedge clk);

    // Not-taken on a counter already at 00 saturates
    do_upd(32'h108, 1'b0, 8'd66, 2'b00);
    do_upd(32'h108, 1'b0, 8'd66, 2'b00);
    repeat (4) @(posedge clk);

    // Flush during UPD_WR with entries queued
    @(posedge clk); #1;
    upd_valid = 1'b1;
    upd_pc    = 32'h10;
    upd_taken = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_flush_rd", {23'd0, tbl_we, tbl_addr}, 32'd4);
    @(posedge clk); #1;
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush_no_write", {31'd0, tbl_we}, 32'd0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    upd_valid = 1'b0;
    @(negedge clk);
    chk("flush_sweep0", {22'd0, tbl_we, init_done, tbl_addr}, 32'h200);
    chk("flush_upd_ready", {31'd0, upd_ready}, 32'd1);
    repeat (255) @(negedge clk);
    chk("flush_sweep255", {23'd0, init_done, tbl_addr}, 32'hFF);
    @(negedge clk);
    chk("flush_init_done", {31'd0, init_done}, 32'd1);
    do_lookup(32'h10, 1'b0, 8'd4);
    repeat (2) @(posedge clk);

    // Async reset in the middle of an init sweep with queued updates
    @(posedge clk); #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    upd_valid = 1'b1;
    upd_pc    = 32'h10;
    upd_taken = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_init_done", {31'd0, init_done}, 32'd0);
    chk("arst_upd_ready", {31'd0, upd_ready}, 32'd1);
    chk("arst_stats", {lookup_stall_count, update_count}, 32'd0);
    @(posedge clk); #1;
    rst_n        = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h10;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (lookup_ready || tbl_addr != i[7:0]) bad++;
    end
    chk("init_stall_bad", bad, 0);
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    wait_init();
    do_upd(32'h30, 1'b1, 8'd12, 2'b10);
    do_upd(32'h30, 1'b1, 8'd12, 2'b11);
    repeat (5) @(posedge clk);
    @(negedge clk);
`ifdef BP_CTRL_STATS_EN
    chk("stall_count", {16'd0, lookup_stall_count}, 32'd5);
    chk("update_count", {16'd0, update_count}, 32'd2);
`else
    chk("stall_count", {16'd0, lookup_stall_count}, 32'd0);
    chk("update_count", {16'd0, update_count}, 32'd0);
`endif
    chk("pred_q_left", pq.size(), 0);
    chk("write_q_left", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
